// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one small ALU (3-bit operands, 2-bit opcode) among
// NREQ requesters. It grants one requester, holds that requester's operands
// on the ALU for HOLD_CYC cycles, captures the ALU result and pulses done
// back to the winner.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN to replace round-robin
// arbitration with fixed priority (lowest index wins). When the macro is
// undefined, arbitration is round-robin starting after the last winner.
module alu_arbiter #(
  parameter int NREQ     = 4,
  parameter int RES_W    = 16,
  parameter int HOLD_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [3*NREQ-1:0]   reqA,
  input  logic [3*NREQ-1:0]   reqB,
  input  logic [2*NREQ-1:0]   reqOp,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [RES_W-1:0]    result,
  output logic                busy,
  output logic [2:0]          portA,
  output logic [2:0]          portB,
  output logic [1:0]          opcode,
  input  logic [RES_W-1:0]    aluRes
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(NREQ - 1);
  localparam logic [NREQ-1:0]  GNT_ONE   = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [NREQ-1:0]    gnt_q;
  logic [NREQ-1:0]    done_q;
  logic [RES_W-1:0]   result_q;
  logic               busy_q;
  logic [2:0]         porta_q;
  logic [2:0]         portb_q;
  logic [1:0]         opcode_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   win_q;

  logic               pick_vld_d;
  logic [IDX_W-1:0]   pick_idx_d;

  // Unpacked views of the packed per-requester operand buses.
  logic [2:0] a_arr  [NREQ];
  logic [2:0] b_arr  [NREQ];
  logic [1:0] op_arr [NREQ];

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr[g]  = reqA[3*g +: 3];
      assign b_arr[g]  = reqB[3*g +: 3];
      assign op_arr[g] = reqOp[2*g +: 2];
    end
  endgenerate

  // Round-robin search: start one past the last winner, wrap modulo NREQ.
  // Returns {found, index}.
  function automatic logic [IDX_W:0] pick_rr(input logic [NREQ-1:0] r,
                                             input logic [IDX_W-1:0] ptr);
    logic             found;
    logic [IDX_W-1:0] w;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    w     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum   = {1'b0, ptr} + (IDX_W+1)'(k);
      sum   = (sum >= (IDX_W+1)'(NREQ)) ? (sum - (IDX_W+1)'(NREQ)) : sum;
      idx   = sum[IDX_W-1:0];
      w     = (!found && r[idx]) ? idx : w;
      found = found | r[idx];
    end
    return {found, w};
  endfunction

  // Fixed-priority search: lowest asserted index wins. Returns {found, index}.
  function automatic logic [IDX_W:0] pick_fixed(input logic [NREQ-1:0] r);
    logic             found;
    logic [IDX_W-1:0] w;
    found = 1'b0;
    w     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w     = (!found && r[IDX_W'(k)]) ? IDX_W'(k) : w;
      found = found | r[IDX_W'(k)];
    end
    return {found, w};
  endfunction

  // Combinational winner selection, consumed only in IDLE.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    {pick_vld_d, pick_idx_d} = pick_fixed(req);
`else
    {pick_vld_d, pick_idx_d} = pick_rr(req, ptr_q);
`endif
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      porta_q  <= 3'd0;
      portb_q  <= 3'd0;
      opcode_q <= 2'd0;
      cnt_q    <= '0;
      ptr_q    <= PTR_RST;
      win_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= '0;
          if (pick_vld_d) begin
            // Operands are latched here; the requester may change them afterwards.
            win_q    <= pick_idx_d;
            gnt_q    <= GNT_ONE << pick_idx_d;
            porta_q  <= a_arr[pick_idx_d];
            portb_q  <= b_arr[pick_idx_d];
            opcode_q <= op_arr[pick_idx_d];
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          busy_q <= 1'b1;
          if (cnt_q == HOLD_LAST) begin
            // Capture even if the winner dropped req during the hold window.
            result_q <= aluRes;
            gnt_q    <= '0;
            done_q   <= gnt_q;
            ptr_q    <= win_q;
            state_q  <= S_DONE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          // No arbitration here: the winner gets one cycle to drop req.
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign portA  = porta_q;
  assign portB  = portb_q;
  assign opcode = opcode_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors, expected completions
// pushed into a scoreboard queue, a monitor pops and compares on every done.
module tb_alu_arbiter;

  localparam int NREQ     = 4;
  localparam int RES_W    = 16;
  localparam int HOLD_CYC = 4;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [3*NREQ-1:0]  reqA;
  logic [3*NREQ-1:0]  reqB;
  logic [2*NREQ-1:0]  reqOp;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [RES_W-1:0]   result;
  logic               busy;
  logic [2:0]         portA;
  logic [2:0]         portB;
  logic [1:0]         opcode;
  logic [RES_W-1:0]   aluRes;

  alu_arbiter #(.NREQ(NREQ), .RES_W(RES_W), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .reqA(reqA), .reqB(reqB), .reqOp(reqOp),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .portA(portA), .portB(portB), .opcode(opcode), .aluRes(aluRes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench ALU: 0 add, 1 subtract, 2 multiply, 3 xor.
  always_comb begin
    case (opcode)
      2'd0:    aluRes = 16'(portA) + 16'(portB);
      2'd1:    aluRes = 16'(portA) - 16'(portB);
      2'd2:    aluRes = 16'(portA) * 16'(portB);
      default: aluRes = 16'(portA ^ portB);
    endcase
  end

  typedef struct packed {
    logic [3:0]  g;
    logic [15:0] r;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int last_done_cyc = -1;
  logic [2:0] oa  [4];
  logic [2:0] ob  [4];
  logic [1:0] oop [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [2:0] a, input logic [2:0] b, input logic [1:0] op);
    oa[i]  = a;
    ob[i]  = b;
    oop[i] = op;
    reqA[3*i +: 3]  = a;
    reqB[3*i +: 3]  = b;
    reqOp[2*i +: 2] = op;
  endtask

  task automatic push_exp(input int w, input logic [15:0] r);
    exp_t e;
    e.g = 4'(1 << w);
    e.r = r;
    sb.push_back(e);
  endtask

  // Waits for requester w's grant, checks its shape, returns at the done negedge.
  task automatic serve(input int w, input bit drop_done, input bit drop_early);
    logic [3:0] eg;
    int n;
    int hi;
    eg = 4'(1 << w);
    n  = 0;
    @(negedge clk);
    while (gnt === 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_winner", 32'(gnt), 32'(eg));
    chk("gnt_operands", 32'({opcode, portB, portA}), 32'({oop[w], ob[w], oa[w]}));
    if (last_done_cyc >= 0) chk("gnt_gap_after_done", 32'(cyc - last_done_cyc), 32'd2);
    hi = 0;
    while (gnt === eg && hi < 10) begin
      if (drop_early && hi == 1) begin
        req[w] = 1'b0;
        reqA[3*w +: 3] = ~oa[w];
      end
      hi++;
      @(negedge clk);
    end
    chk("gnt_cycles", 32'(hi), 32'(HOLD_CYC));
    chk("done_pulse", 32'(done), 32'(eg));
    chk("busy_in_done", 32'(busy), 32'd1);
    last_done_cyc = cyc;
    if (drop_done) req[w] = 1'b0;
  endtask

  // Scoreboard monitor: every done must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && done !== 4'b0000) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=%b expected no completion", done);
      end else begin
        e = sb.pop_front();
        chk("sb_done", 32'(done), 32'(e.g));
        chk("sb_result", 32'(result), 32'(e.r));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord3[5];
    int ndone;
    int n;
`ifdef ALU_ARB_FIXED_PRIO_EN
    ord3 = '{0, 0, 0, 0, 0};
`else
    ord3 = '{0, 1, 2, 3, 0};
`endif

    // Reset held with all requests up.
    rst   = 1'b1;
    req   = 4'b1111;
    reqA  = 12'hFFF;
    reqB  = 12'hFFF;
    reqOp = 8'hFF;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_gnt_done", 32'({gnt, done}), 32'd0);
      chk("rst_busy_result", 32'({busy, result}), 32'd0);
      chk("rst_ports", 32'({portA, portB, opcode}), 32'd0);
    end
    rst   = 1'b0;
    req   = 4'b0000;
    reqA  = 12'h000;
    reqB  = 12'h000;
    reqOp = 8'h00;

    // Single op: requester 1, 3 + 2.
    set_ops(1, 3'd3, 3'd2, 2'd0);
    req = 4'b0010;
    push_exp(1, 16'd5);
    last_done_cyc = -1;
    serve(1, 1'b1, 1'b0);
    chk("single_result", 32'(result), 32'd5);
    @(negedge clk);
    chk("single_busy_low", 32'(busy), 32'd0);
    chk("single_done_low", 32'(done), 32'd0);

    // Reset to bring the pointer back, then all four held high.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_result", 32'(result), 32'd0);
    set_ops(0, 3'd1, 3'd1, 2'd0);
    set_ops(1, 3'd2, 3'd3, 2'd1);
    set_ops(2, 3'd6, 3'd3, 2'd2);
    set_ops(3, 3'd5, 3'd3, 2'd3);
    req = 4'b1111;
    last_done_cyc = -1;
    for (int i = 0; i < 5; i++) begin
      case (ord3[i])
        0:       push_exp(0, 16'd2);
        1:       push_exp(1, 16'hFFFF);
        2:       push_exp(2, 16'h0012);
        default: push_exp(3, 16'd6);
      endcase
    end
    for (int i = 0; i < 5; i++) serve(ord3[i], 1'b0, 1'b0);
    req = 4'b0000;

    // Requester 2 drops req one cycle into its grant; op still completes.
    set_ops(2, 3'd7, 3'd0, 2'd1);
    req = 4'b0100;
    push_exp(2, 16'd7);
    last_done_cyc = -1;
    serve(2, 1'b1, 1'b1);
    chk("drop_result", 32'(result), 32'd7);
    req = 4'b0000;

    // Reset in the second grant cycle aborts the op.
    set_ops(0, 3'd1, 3'd1, 2'd0);
    req = 4'b0001;
    n = 0;
    @(negedge clk);
    while (gnt === 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    chk("abort_gnt_done_clear", 32'({gnt, done}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 4'b0000) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // Requesters 0 and 2 held high.
    set_ops(0, 3'd1, 3'd1, 2'd0);
    set_ops(2, 3'd6, 3'd3, 2'd2);
    req = 4'b0101;
    last_done_cyc = -1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) push_exp(0, 16'd2);
    for (int i = 0; i < 3; i++) serve(0, 1'b0, 1'b0);
`else
    for (int i = 0; i < 4; i++) push_exp((i % 2 == 0) ? 0 : 2, (i % 2 == 0) ? 16'd2 : 16'h0012);
    for (int i = 0; i < 4; i++) serve((i % 2 == 0) ? 0 : 2, 1'b0, 1'b0);
`endif
    req = 4'b0000;

    repeat (6) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance (3-bit operands, 2-bit opcode) among NREQ requesters, for example the switch panel, a self-test sequencer and a display-refresh task.
- Arbitrates the requests and latches the winner's operands and opcode.
- Drives the ALU for a fixed settle/hold window, then captures the ALU result and pulses done back to the winner.
- Sits between the requesters and the `alu` datapath; `result` also feeds the display path.

Parameters:
- NREQ, 4, number of requesters (2..8).
- RES_W, 16, width of ALU result bus and captured result.
- HOLD_CYC, 4, cycles the ALU inputs are held with grant asserted before capture (1..65535).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  request, one bit per requester; level, held until done.
- reqA  in  3*NREQ  operand A; requester i at [3i+2:3i].
- reqB  in  3*NREQ  operand B; same packing.
- reqOp  in  2*NREQ  opcode; requester i at [2i+1:2i].
- gnt  out  NREQ  one-hot grant; high while the ALU is owned.
- done  out  NREQ  one-hot, 1-cycle completion pulse.
- result  out  RES_W  last captured ALU result.
- busy  out  1  high when state is not IDLE.
- portA  out  3  to alu.portA.
- portB  out  3  to alu.portB.
- opcode  out  2  to alu.opcode.
- aluRes  in  RES_W  from alu; combinational result of portA/portB/opcode.

Behaviour:
- Reset (rst high at an edge): state=IDLE; gnt, done, result, busy, portA, portB, opcode, hold counter = 0; RR pointer = NREQ-1, so requester 0 wins first.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner w, latch reqA/reqB/reqOp slice w into portA/portB/opcode, set gnt[w], clear counter, go to RUN.
  - Grant is visible 1 cycle after req is sampled.
- RUN:
  - gnt[w] stays high exactly HOLD_CYC cycles; counter increments each cycle.
  - On the edge where counter==HOLD_CYC-1: result <= aluRes, gnt <= 0, done[w] <= 1, RR pointer <= w, go to DONE.
- DONE:
  - done[w] is high for this one cycle; it is cleared on the next edge; state goes to IDLE.
  - No arbitration is evaluated in DONE.
- Round-robin: search starts at pointer+1 and wraps modulo NREQ; the first asserted req wins.
- Requester protocol:
  - Operands need only be valid in the cycle req is sampled in IDLE; they are latched at grant.
  - A requester must drop req in its done cycle. If req is still high in the following IDLE cycle, it is a new request.
- req dropped during RUN: the operation completes; done still pulses; result is still captured.
- portA/portB/opcode hold their last latched value outside RUN, so the display does not glitch.
- result changes only at capture or reset.
- Throughput: one operation per HOLD_CYC+2 cycles. Next gnt rises 2 cycles after a done pulse.
- Reset mid-operation: next cycle is IDLE with gnt=0; no done is issued for the aborted op; result=0.
- rst has priority over all other events in the same cycle.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; RR pointer unused; a continuously requesting requester 0 starves the others.
- Undefined: round-robin as in Behaviour.

Test Plan:
- Reset: rst high 3 cycles with req=4'b1111 -> gnt=0, done=0, busy=0, result=0, portA/portB/opcode=0 throughout.
- Single op (HOLD_CYC=4; bench ALU model: op0 = A+B):
  - Stimulus: req=4'b0010, A=3, B=2, op=0.
  - gnt=4'b0010 from cycle+1 for exactly 4 cycles; portA=3, portB=2, opcode=0.
  - done=4'b0010 for 1 cycle; result=5; busy falls with return to IDLE.
- All four req held high: grant order 0,1,2,3,0; each gnt rises exactly 2 cycles after the previous done; done is always one-hot.
- Drop req[2] one cycle after gnt[2] rises (A=7, B=0, op=1): done[2] still pulses after 4 grant cycles; result = bench ALU(7,0,1).
- Reset mid-op: rst high in the 2nd grant cycle for 1 cycle -> next cycle gnt=0, busy=0, result=0; no done pulse follows.
- req=4'b0101 held high:
  - Without the macro: grants alternate 0,2,0,2.
  - With ALU_ARB_FIXED_PRIO_EN: grants are 0,0,0.
